md_unit: RTL
============

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5, number of busy cycles for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10, number of busy cycles for DIV/DIVU.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset; state clears immediately when reset=0, independent of clk.
REQ-005 start  input  1  qualifies op in the current cycle.
REQ-006 op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; values 7-15 are treated as NONE.
REQ-007 a  input  32  operand rs, taken from the register file read/forward path.
REQ-008 b  input  32  operand rt, taken from the register file read/forward path.
REQ-009 busy  output  1  high while a multiply/divide is in flight.
REQ-010 hi  output  32  architectural HI register.
REQ-011 lo  output  32  architectural LO register.

Function
REQ-012 The unit SHALL have exactly two states, IDLE and BUSY, plus a down-counter cnt wide enough to hold max(MULT_CYCLES, DIV_CYCLES).
REQ-013 In IDLE, a posedge with start=1 and op in {MULT, MULTU, DIV, DIVU} SHALL do four things: latch a and b, latch op, load cnt with MULT_CYCLES or DIV_CYCLES, and enter BUSY.
REQ-014 busy SHALL equal (state==BUSY) as a registered signal; it rises after the accepting edge T0 and stays high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
REQ-015 In BUSY, each posedge SHALL decrement cnt; on the edge where cnt==1 the unit writes the result to HI/LO, returns to IDLE and deasserts busy.
REQ-016 The new hi/lo values therefore SHALL first be visible after edge T0+N, in the same cycle that busy is low.
REQ-017 Until edge T0+N, hi/lo SHALL hold their previous values.
REQ-018 MULT: {hi,lo} SHALL be the 64-bit signed product of the latched operands.
REQ-019 MULTU: {hi,lo} SHALL be the 64-bit unsigned product of the latched operands.
REQ-020 DIV: lo SHALL be the signed quotient truncated toward zero and hi the signed remainder, whose sign follows the dividend.
REQ-021 DIVU: lo SHALL be the unsigned quotient and hi the unsigned remainder.
REQ-022 DIV/DIVU with latched b==0 SHALL still run DIV_CYCLES with busy high, then leave hi/lo unchanged.
REQ-023 Signed DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-024 MTHI (start=1, state IDLE) SHALL write hi<=a at the posedge, with no busy cycle; lo is unchanged.
REQ-025 MTLO (start=1, state IDLE) SHALL write lo<=a at the posedge, with no busy cycle; hi is unchanged.
REQ-026 In BUSY, start=1 with any op SHALL be ignored; no operand latch, no HI/LO write, no counter change. Upstream hazard logic stalls on busy|start, and this rule is the safety net.
REQ-027 start=0, or op=NONE, SHALL leave all state unchanged.
REQ-028 Operand changes on a/b during BUSY SHALL NOT affect the result; only the values latched at T0 are used.
REQ-029 Result computation MAY be combinational on the latched operands or iterative, provided REQ-015 to REQ-017 timing holds exactly.

Reset
REQ-030 While reset=0, the unit SHALL immediately force: state=IDLE, busy=0, cnt=0, hi=0, lo=0, latched operands=0.
REQ-031 Reset asserted mid-operation SHALL abort the operation with no HI/LO write.
REQ-032 After reset releases, the first posedge SHALL accept a new start normally.

Verification
REQ-033 MULT, a=0xFFFFFFFE, b=3 -> busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-034 MULTU, a=0xFFFFFFFE, b=3 -> after 5 busy cycles hi=0x00000002, lo=0xFFFFFFFA.
REQ-035 DIV, a=0xFFFFFFF9 (-7), b=2 -> busy for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU, a=7, b=2 -> lo=3, hi=1.
REQ-036 MTHI a=0x12345678, then DIVU a=5, b=0 -> hi=0x12345678 immediately; after 10 busy cycles hi and lo are unchanged.
REQ-037 Start MULT a=2, b=3; at busy cycle 2 issue start=1 op=MTLO a=0xDEAD -> MTLO is ignored; after cycle 5 lo=6, hi=0.
REQ-038 Start DIV; assert reset=0 asynchronously at busy cycle 4 -> busy, hi and lo go to 0 without waiting for a clock edge; after release, MULTU a=4, b=4 gives lo=16 after 5 cycles.

Source files
------------

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit -- multi-cycle multiply/divide unit with architectural HI/LO.
//
// MULT/MULTU/DIV/DIVU latch their operands when accepted, hold busy high for
// MULT_CYCLES or DIV_CYCLES cycles, then write HI/LO on the final busy edge.
// MTHI/MTLO write HI/LO directly from operand a in a single edge.
//
// Ports:
//   clk    in   1   single clock, all state updates on posedge
//   reset  in   1   asynchronous active-low reset
//   start  in   1   qualifies op in the current cycle
//   op     in   4   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
//                   (7-15 behave as NONE)
//   a      in  32   operand rs
//   b      in  32   operand rt
//   busy   out  1   high while a multiply/divide is in flight
//   hi     out 32   architectural HI register
//   lo     out 32   architectural LO register
// ---------------------------------------------------------------------------
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6
    } op_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    op_t                r_op;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic               w_long_op;
    logic               w_is_mult;
    logic               w_accept;
    logic               w_done;

    logic [63:0]        w_prod_s;
    logic [63:0]        w_prod_u;
    logic [31:0]        w_a_mag;
    logic [31:0]        w_b_mag;
    logic [31:0]        w_q_mag;
    logic [31:0]        w_r_mag;
    logic [31:0]        w_q_s;
    logic [31:0]        w_r_s;
    logic [31:0]        w_q_u;
    logic [31:0]        w_r_u;

    logic               w_res_valid;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;

    assign w_long_op = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign w_is_mult = (op == OP_MULT) || (op == OP_MULTU);

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && w_long_op) begin
                    w_accept     = 1'b1;
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                // Last busy edge: result is written on this same edge.
                if (r_cnt == CNT_W'(1)) begin
                    w_done       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------- Result datapath (combinational on latched operands) ----
    assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
    assign w_prod_u = {32'h0, r_a} * {32'h0, r_b};

    // Signed divide via magnitudes: avoids the overflowing 0x80000000 / -1
    // case of a native signed divide and truncates toward zero by construction.
    assign w_a_mag = r_a[31] ? (32'h0 - r_a) : r_a;
    assign w_b_mag = r_b[31] ? (32'h0 - r_b) : r_b;
    assign w_q_mag = (w_b_mag != 32'h0) ? (w_a_mag / w_b_mag) : 32'h0;
    assign w_r_mag = (w_b_mag != 32'h0) ? (w_a_mag % w_b_mag) : 32'h0;
    assign w_q_s   = (r_a[31] ^ r_b[31]) ? (32'h0 - w_q_mag) : w_q_mag;
    assign w_r_s   = r_a[31] ? (32'h0 - w_r_mag) : w_r_mag;   // sign follows dividend
    assign w_q_u   = (r_b != 32'h0) ? (r_a / r_b) : 32'h0;
    assign w_r_u   = (r_b != 32'h0) ? (r_a % r_b) : 32'h0;

    always_comb begin
        w_res_valid = 1'b0;
        w_res_hi    = r_hi;
        w_res_lo    = r_lo;
        case (r_op)
            OP_MULT:  begin w_res_valid = 1'b1; {w_res_hi, w_res_lo} = w_prod_s; end
            OP_MULTU: begin w_res_valid = 1'b1; {w_res_hi, w_res_lo} = w_prod_u; end
            // Divide by zero still burns the busy cycles but writes nothing.
            OP_DIV:   begin w_res_valid = (r_b != 32'h0); w_res_hi = w_r_s; w_res_lo = w_q_s; end
            OP_DIVU:  begin w_res_valid = (r_b != 32'h0); w_res_hi = w_r_u; w_res_lo = w_q_u; end
            default:  w_res_valid = 1'b0;
        endcase
    end

    // ---------------- Operand latch, counter and HI/LO ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= OP_NONE;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            if (w_accept) begin
                r_a   <= a;
                r_b   <= b;
                r_op  <= op_t'(op);
                r_cnt <= w_is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            // MTHI/MTLO only act in IDLE; any start while BUSY is dropped.
            if (w_done && w_res_valid) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if (r_state == S_IDLE && start && op == OP_MTHI) begin
                r_hi <= a;
            end else if (r_state == S_IDLE && start && op == OP_MTLO) begin
                r_lo <= a;
            end
        end
    end

    assign busy = (r_state == S_BUSY);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
